alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Registered execute stage wrapped around the 32-bit combinational `alu`. Operation requests arrive through a valid/ready handshake and are buffered in a small in-order request FIFO. The head request drives `alu` combinationally, and its result and flags are captured in an output register with its own valid/ready handshake. The stage also keeps a sticky overflow status bit for software polling.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `TAG_W`, 4: width of the opaque request tag carried alongside each operation.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `flush` in 1: synchronous discard of all buffered and output state.
- `in_valid` in 1: request present.
- `in_ready` out 1: stage can accept a request.
- `in_cmd` in 3: ALU command (see `alu_pkg`).
- `in_a` in 32: operand A.
- `in_b` in 32: operand B.
- `in_tag` in `TAG_W`: request tag.
- `out_valid` out 1: output register holds a result.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out 32: registered ALU result.
- `out_carry` out 1: registered carryout.
- `out_zero` out 1: registered zero flag.
- `out_overflow` out 1: registered overflow.
- `out_tag` out `TAG_W`: tag of the result.
- `level` out `$clog2(DEPTH)+1`: FIFO occupancy.
- `sticky_ovf` out 1: set by any delivered overflow.
- `sticky_clr` in 1: clear `sticky_ovf`.

## Operation
- **Push:** a request is accepted when `in_valid && in_ready`.
  - `in_ready = (level < DEPTH) && !flush`.
  - `in_ready` depends only on registered occupancy, never on a same-cycle pop, so a full FIFO deasserts ready even while popping.
- **FIFO:** write/read pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`. `level` is a separate counter.
  - Push only: +1. Pop only: −1. Push and pop together: unchanged.
- **Execute:** when `level != 0`, the FIFO head's `cmd`, `a` and `b` drive `alu`. The ALU outputs are used unmodified; carry and overflow are already gated to ADD/SUB inside `alu`.
- **Output load:** occurs when `level != 0 && (!out_valid || out_ready)`. On load:
  - the head is popped;
  - `out_*` and `out_tag` take the ALU and head values;
  - `out_valid` is set to 1.
- **Output release:** when `out_valid && out_ready` and no load occurs, `out_valid` goes to 0 and the data outputs hold their last value.
- **Sticky overflow:** `sticky_ovf` sets on any output load with ALU overflow = 1, and clears on `sticky_clr`. If set and clear happen in the same cycle, set wins.
- **Flush:**
  - Next edge: pointers, `level` and `out_valid` go to 0; no push and no load occurs.
  - `sticky_ovf` is unaffected.
  - Data registers keep stale values.
- **Reset (`reset_n = 0` at an edge):**
  - All outputs go to 0: `out_valid`, `out_result`, `out_carry`, `out_zero`, `out_overflow`, `out_tag`, `level`, `sticky_ovf`.
  - Pointers are cleared.
  - `in_ready` reads 0 while `reset_n` is low and 1 on the first cycle after release.
  - A reset mid-stream discards all in-flight requests with no partial output.
  - Reset has priority over `flush`.

## Timing
- **Latency:** a request accepted at edge N into an empty stage with a free output register loads at edge N+1. `out_valid` is high in the cycle following N+1. There is no combinational input-to-output path.
- **Throughput:** one result per cycle while `out_ready = 1` and the FIFO is non-empty.
- **Capacity:** `DEPTH` requests in the FIFO plus 1 in the output register.
- **Combinational paths:**
  - `in_ready` is a function of registered state and `flush` only.
  - `out_*` are direct register outputs.
  - The only long combinational path is FIFO head → `alu` → output register.

## Structure
- **`alu_pkg`** holds:
  - the command constants: `ALU_ADD=3'd0`, `ALU_SUB=3'd1`, `ALU_XOR=3'd2`, `ALU_SLT=3'd3`, `ALU_AND=3'd4`, `ALU_NAND=3'd5`, `ALU_NOR=3'd6`, `ALU_OR=3'd7`;
  - the request struct `alu_req_t` {cmd, a, b, tag}, parameterised through `TAG_W`.
- **Sub-module `alu_req_fifo`:**
  - parameters `DEPTH` and the payload width;
  - ports: push, pop, head, `level`, flush;
  - implements pointer wrap and occupancy.
- **Top:** instantiates `alu_req_fifo`, the existing `alu`, the output register and the sticky bit.

## Test plan
- **Overflow:** ADD A=0x7FFF_FFFF, B=0x0000_0001, tag 3.
  - Expect result 0x8000_0000, carry 0, overflow 1, zero 0, tag 3.
  - `sticky_ovf` = 1 after the load; clears one cycle after `sticky_clr`.
  - Assert `sticky_clr` in the same cycle as a second overflow load: `sticky_ovf` stays 1.
- **Zero and SLT:** SUB 5−5 → result 0, zero 1, carry 1. SLT A=0xFFFF_FFFF, B=1 → result 1. SLT 1, 0xFFFF_FFFF → result 0.
- **Backpressure:** hold `out_ready=0` and offer 7 requests with tags 0–6.
  - Exactly 5 are accepted (`level` = 4, `in_ready` = 0).
  - Raise `out_ready`: tags 0–4 emerge in order on consecutive cycles with correct results.
- **Wrap and simultaneous push/pop:** stream 20 back-to-back requests with `out_ready=1`. Expect `level` ≤ 1, one result per cycle after a 2-edge start, and pointers wrapping with no loss or duplication.
- **Flush:** with 3 requests queued and `out_valid=1`, pulse `flush` together with `in_valid`.
  - Next cycle: `level` 0, `out_valid` 0, the new request not accepted.
  - `sticky_ovf` unchanged.
- **Reset mid-stream:** with 2 queued and one output pending, drive `reset_n=0` for 1 cycle.
  - All outputs read 0 while reset is low; `in_ready` reads 0 during reset and 1 the cycle after release.
  - No stale result appears afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU execute stage.
//   - ALU command encodings driven on the 3-bit cmd inputs
//   - default request tag width and the request record {cmd, a, b, tag}
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_NAND = 3'd5;
    localparam logic [2:0] ALU_NOR  = 3'd6;
    localparam logic [2:0] ALU_OR   = 3'd7;

    localparam int ALU_TAG_W = 4;

    // Request record at the default tag width. The stage declares the same
    // layout locally so that its own TAG_W parameter can resize the tag.
    typedef struct packed {
        logic [2:0]           cmd;
        logic [31:0]          a;
        logic [31:0]          b;
        logic [ALU_TAG_W-1:0] tag;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// alu: 32-bit combinational ALU.
//   a, b      : operands
//   cmd       : operation (alu_pkg command constants)
//   result    : operation result
//   carryout  : carry out of ADD / no-borrow of SUB, 0 for other commands
//   zero      : result == 0
//   overflow  : signed overflow of ADD/SUB, 0 for other commands
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  cmd,
    output logic [31:0] result,
    output logic        carryout,
    output logic        zero,
    output logic        overflow
);

    logic        is_sub;
    logic        is_arith;
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic        arith_ovf;
    logic        slt;

    // SUB is computed as a + ~b + 1, so carry out means "no borrow".
    assign is_sub   = (cmd == ALU_SUB);
    assign is_arith = (cmd == ALU_ADD) || is_sub;
    assign b_eff    = is_sub ? ~b : b;
    assign sum      = {1'b0, a} + {1'b0, b_eff} + {32'd0, is_sub};

    // Overflow: both effective operands share a sign the sum does not.
    assign arith_ovf = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    assign slt       = ($signed(a) < $signed(b));

    always_comb begin
        result = 32'd0;
        case (cmd)
            ALU_ADD:  result = sum[31:0];
            ALU_SUB:  result = sum[31:0];
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {31'd0, slt};
            ALU_AND:  result = a & b;
            ALU_NAND: result = ~(a & b);
            ALU_NOR:  result = ~(a | b);
            ALU_OR:   result = a | b;
            default:  result = 32'd0;
        endcase
    end

    assign carryout = is_arith && sum[32];
    assign overflow = is_arith && arith_ovf;
    assign zero     = (result == 32'd0);

endmodule

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: in-order request buffer with separate occupancy counter.
//   clk, reset_n : clock, synchronous active-low reset
//   flush        : synchronous discard of all entries
//   push, wdata  : write one entry (caller guarantees not full)
//   pop          : remove the head entry (caller guarantees not empty)
//   head         : current head entry (stale when level == 0)
//   level        : number of entries held, 0..DEPTH
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset: entries are only read while level != 0.
    always_ff @(posedge clk) begin
        if (reset_n && !flush && push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered execute stage around the 32-bit alu.
//   clk, reset_n         : clock, synchronous active-low reset (beats flush)
//   flush                : discard queued requests and the pending result
//   in_valid/in_ready    : request handshake; in_cmd, in_a, in_b, in_tag payload
//   out_valid/out_ready  : result handshake; out_result, out_carry, out_zero,
//                          out_overflow, out_tag are direct register outputs
//   level                : request FIFO occupancy
//   sticky_ovf/sticky_clr: sticky overflow status and its clear
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Valid may not depend on ready; in_ready depends only on
// registered occupancy, reset_n and flush, never on a same-cycle pop.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = ALU_TAG_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_cmd,
    input  logic [31:0]            in_a,
    input  logic [31:0]            in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_result,
    output logic                   out_carry,
    output logic                   out_zero,
    output logic                   out_overflow,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0] level,
    output logic                   sticky_ovf,
    input  logic                   sticky_clr
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [2:0]       cmd;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } stage_req_t;

    stage_req_t  wr_req;
    stage_req_t  head_req;
    logic        do_push;
    logic        do_load;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_ovf;

    assign in_ready = reset_n && !flush && (level < LVL_W'(DEPTH));
    assign do_push  = in_valid && in_ready;

    // Load whenever a request is waiting and the output register is free or
    // being drained this cycle. Flush blocks the load.
    assign do_load  = (level != '0) && (!out_valid || out_ready) && !flush;

    assign wr_req = '{cmd: in_cmd, a: in_a, b: in_b, tag: in_tag};

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(stage_req_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (do_push),
        .wdata   (wr_req),
        .pop     (do_load),
        .head    (head_req),
        .level   (level)
    );

    alu u_alu (
        .a        (head_req.a),
        .b        (head_req.b),
        .cmd      (head_req.cmd),
        .result   (alu_result),
        .carryout (alu_carry),
        .zero     (alu_zero),
        .overflow (alu_ovf)
    );

    // Output register. Flush only drops valid; data keeps stale contents.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_result   <= 32'd0;
            out_carry    <= 1'b0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_tag      <= '0;
        end else if (flush) begin
            out_valid    <= 1'b0;
        end else if (do_load) begin
            out_valid    <= 1'b1;
            out_result   <= alu_result;
            out_carry    <= alu_carry;
            out_zero     <= alu_zero;
            out_overflow <= alu_ovf;
            out_tag      <= head_req.tag;
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
        end
    end

    // Sticky overflow: a setting load beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sticky_ovf <= 1'b0;
        end else if (do_load && alu_ovf) begin
            sticky_ovf <= 1'b1;
        end else if (sticky_clr) begin
            sticky_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_cmd;
    logic [31:0]       in_a;
    logic [31:0]       in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic              out_carry;
    logic              out_zero;
    logic              out_overflow;
    logic [TAG_W-1:0]  out_tag;
    logic [$clog2(DEPTH):0] level;
    logic              sticky_ovf;
    logic              sticky_clr;

    alu_exec_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cmd       (in_cmd),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_tag      (out_tag),
        .level        (level),
        .sticky_ovf   (sticky_ovf),
        .sticky_clr   (sticky_clr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct {
        logic [2:0]       cmd;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } mreq_t;

    mreq_t            mq[$];
    bit               m_ov;
    logic [31:0]      m_res;
    logic             m_c, m_z, m_o;
    logic [TAG_W-1:0] m_tag;
    logic             m_sticky;
    logic             seen_rdy;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ALU behaviour from the arithmetic definition of each command.
    task automatic model_alu(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic c, output logic z,
                             output logic o);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 32'd0; c = 1'b0; o = 1'b0;
        case (cmd)
            ALU_ADD: begin
                r = a + b;
                c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                s = sa + sb;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_SUB: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_XOR:  r = a ^ b;
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_AND:  r = a & b;
            ALU_NAND: r = ~(a & b);
            ALU_NOR:  r = ~(a | b);
            default:  r = a | b;
        endcase
        z = (r == 32'd0);
    endtask

    // One clock cycle: check in_ready before the edge, advance the model at
    // the edge, then compare every output against the model.
    task automatic cycle();
        bit    exp_rdy, acc, ld;
        mreq_t req, e;
        logic [31:0] r;
        logic c, z, o;
        #2;
        exp_rdy = reset_n && !flush && (mq.size() < DEPTH);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        seen_rdy = in_ready;
        acc = exp_rdy && in_valid;
        ld  = (mq.size() > 0) && (!m_ov || out_ready);
        req = '{cmd: in_cmd, a: in_a, b: in_b, tag: in_tag};
        @(posedge clk);
        if (!reset_n) begin
            mq.delete();
            m_ov = 0; m_res = 0; m_c = 0; m_z = 0; m_o = 0; m_tag = 0; m_sticky = 0;
        end else if (flush) begin
            mq.delete();
            m_ov = 0;
            if (sticky_clr) m_sticky = 0;
        end else begin
            o = 1'b0;
            if (ld) begin
                e = mq.pop_front();
                model_alu(e.cmd, e.a, e.b, r, c, z, o);
                m_res = r; m_c = c; m_z = z; m_o = o; m_tag = e.tag;
                m_ov = 1;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            if (ld && o) m_sticky = 1;
            else if (sticky_clr) m_sticky = 0;
            if (acc) mq.push_back(req);
        end
        #1;
        check("out_valid",    {31'd0, out_valid},    {31'd0, m_ov});
        check("out_result",   out_result,            m_res);
        check("out_carry",    {31'd0, out_carry},    {31'd0, m_c});
        check("out_zero",     {31'd0, out_zero},     {31'd0, m_z});
        check("out_overflow", {31'd0, out_overflow}, {31'd0, m_o});
        check("out_tag",      {28'd0, out_tag},      {28'd0, m_tag});
        check("level",        {29'd0, level},        mq.size());
        check("sticky_ovf",   {31'd0, sticky_ovf},   {31'd0, m_sticky});
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        in_valid = 1'b1; in_cmd = cmd; in_a = a; in_b = b; in_tag = tag;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] pick[5];
        int k;
        pick[0] = 32'h0000_0000; pick[1] = 32'h0000_0001; pick[2] = 32'h7FFF_FFFF;
        pick[3] = 32'h8000_0000; pick[4] = 32'hFFFF_FFFF;
        k = int'($urandom_range(0, 7));
        if (k < 5) return pick[k];
        return $urandom;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int acc_cnt;
        int nvalid;

        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_cmd = 3'd0; in_a = 32'd0;
        in_b = 32'd0; in_tag = '0; out_ready = 1'b0; sticky_clr = 1'b0;
        m_ov = 0; m_res = 0; m_c = 0; m_z = 0; m_o = 0; m_tag = 0; m_sticky = 0;
        seen_rdy = 1'b0;

        // Reset state
        cycle(); cycle();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_sticky", {31'd0, sticky_ovf}, 32'd0);
        reset_n = 1'b1;
        out_ready = 1'b1;

        // Overflow and sticky bit
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3); cycle();
        idle(); cycle();
        check("ovf_valid", {31'd0, out_valid}, 32'd1);
        check("ovf_result", out_result, 32'h8000_0000);
        check("ovf_carry", {31'd0, out_carry}, 32'd0);
        check("ovf_flag", {31'd0, out_overflow}, 32'd1);
        check("ovf_zero", {31'd0, out_zero}, 32'd0);
        check("ovf_tag", {28'd0, out_tag}, 32'd3);
        check("ovf_sticky_set", {31'd0, sticky_ovf}, 32'd1);
        sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0;
        check("ovf_sticky_clr", {31'd0, sticky_ovf}, 32'd0);
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 4'd5); cycle();
        idle(); sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0;
        check("ovf_set_wins", {31'd0, sticky_ovf}, 32'd1);

        // Zero and SLT
        drive(ALU_SUB, 32'd5, 32'd5, 4'd1); cycle();
        drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 4'd2); cycle();
        check("sub_result", out_result, 32'd0);
        check("sub_zero", {31'd0, out_zero}, 32'd1);
        check("sub_carry", {31'd0, out_carry}, 32'd1);
        drive(ALU_SLT, 32'd1, 32'hFFFF_FFFF, 4'd4); cycle();
        check("slt_neg_lt", out_result, 32'd1);
        idle(); cycle();
        check("slt_pos_ge", out_result, 32'd0);
        check("slt_carry_gated", {31'd0, out_carry}, 32'd0);
        cycle(); cycle();

        // Backpressure: 7 offers, 5 accepted
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            drive(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 4'(i));
            cycle();
            if (seen_rdy) acc_cnt++;
        end
        idle();
        check("bp_accepted", acc_cnt, 32'd5);
        check("bp_level", {29'd0, level}, 32'd4);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        check("bp_tag0", {28'd0, out_tag}, 32'd0);
        for (int k = 1; k < 5; k++) begin
            cycle();
            check("bp_order_valid", {31'd0, out_valid}, 32'd1);
            check("bp_order_tag", {28'd0, out_tag}, k);
        end
        cycle();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Back-to-back streaming with pointer wrap
        nvalid = 0;
        for (int i = 0; i < 24; i++) begin
            if (i < 20) drive(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 4'(i));
            else idle();
            cycle();
            check("stream_level_le1", {31'd0, (level <= 1)}, 32'd1);
            if (out_valid) begin
                check("stream_tag", {28'd0, out_tag}, nvalid % 16);
                nvalid++;
            end
        end
        check("stream_count", nvalid, 32'd20);

        // Flush with 3 queued and a pending output
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 4'(i));
            cycle();
        end
        check("pre_flush_level", {29'd0, level}, 32'd3);
        check("pre_flush_valid", {31'd0, out_valid}, 32'd1);
        drive(ALU_OR, 32'h1234_5678, 32'd0, 4'd9);
        flush = 1'b1; cycle(); flush = 1'b0; idle();
        check("flush_level", {29'd0, level}, 32'd0);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_sticky", {31'd0, sticky_ovf}, 32'd1);
        cycle();
        check("flush_no_accept", {29'd0, level}, 32'd0);
        check("flush_still_empty", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 4'(i + 10));
            cycle();
        end
        reset_n = 1'b0;
        drive(ALU_ADD, 32'd1, 32'd1, 4'd15);
        #2;
        check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        cycle();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", out_result, 32'd0);
        check("mid_rst_tag", {28'd0, out_tag}, 32'd0);
        check("mid_rst_level", {29'd0, level}, 32'd0);
        check("mid_rst_sticky", {31'd0, sticky_ovf}, 32'd0);
        reset_n = 1'b1; idle();
        #1;
        check("rst_in_ready_high", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rst_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0)
                drive(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
                      4'($urandom_range(0, 15)));
            else
                idle();
            out_ready  = ($urandom_range(0, 3) != 0);
            sticky_clr = ($urandom_range(0, 15) == 0);
            flush      = ($urandom_range(0, 31) == 0);
            cycle();
        end
        idle(); flush = 1'b0; sticky_clr = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        check("final_empty", {29'd0, level}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
